pcounter_cfg_resp: RTL and testbench

//  Device-side responder for the pcounter config bus (cfg_enable/rd_wr/addr/wdata).
//  - Decodes bus writes into a 6-register file; returns read data one cycle later.
//  - Runs a programmable up/down step counter with limit, wrap/saturate, status and irq.
//  - Sits inside the DUT, opposite the bench BFM that drives the config interface.

---
 rtl/pcounter_cfg_resp.sv | 189 ++++++++++++++++++
 tb/tb_pcounter_cfg_resp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcounter_cfg_resp.sv
// rtl/pcounter_cfg_resp.sv - config-bus register responder with programmable step counter
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   cfg_enable, cfg_rd_wr   bus strobe; rd_wr=1 write, 0 read
//   cfg_addr, cfg_wdata     register address and write data
//   cfg_rdata, cfg_rvalid   registered read data and its one-cycle valid pulse
//   cnt_tick                counter advance qualifier
//   count                   current counter value
//   term_pulse              one-cycle pulse after a terminal step
//   irq                     level, OR of enabled sticky status bits
module pcounter_cfg_resp #(
    parameter int          DATA_W    = 10,
    parameter int          ADDR_W    = 3,
    parameter int unsigned RST_LIMIT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_enable,
    input  logic              cfg_rd_wr,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic [DATA_W-1:0] cfg_rdata,
    output logic              cfg_rvalid,
    input  logic              cnt_tick,
    output logic [DATA_W-1:0] count,
    output logic              term_pulse,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_LOAD   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_LIMIT  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_STEP   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(5);

    // CTRL fields that hold state; clr/load are write-only strobes
    logic              run;
    logic              down;
    logic              wrap;
    logic              irq_term_en;
    logic              irq_ovf_en;
    logic [DATA_W-1:0] load_reg;
    logic [DATA_W-1:0] limit_reg;
    logic [DATA_W-1:0] step_reg;
    logic              term_sticky;
    logic              ovf_sticky;

    logic wr;
    logic rd;
    logic wr_ctrl;
    logic wr_status;
    logic ctrl_clr;
    logic ctrl_load;

    assign wr        = cfg_enable & cfg_rd_wr;
    assign rd        = cfg_enable & ~cfg_rd_wr;
    assign wr_ctrl   = wr && (cfg_addr == A_CTRL);
    assign wr_status = wr && (cfg_addr == A_STATUS);
    assign ctrl_clr  = wr_ctrl & cfg_wdata[3];
    assign ctrl_load = wr_ctrl & cfg_wdata[4];

    // Counter next-state. The step always evaluates the CTRL/LIMIT/STEP values
    // held before this edge; a same-cycle clr/load strobe overrides the step
    // entirely, so no terminal/overflow event is raised in that cycle.
    logic              step_en;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] count_nxt;
    logic              term_evt;
    logic              ovf_evt;
    logic              run_autoclr;

    always_comb begin
        count_nxt   = count;
        term_evt    = 1'b0;
        ovf_evt     = 1'b0;
        run_autoclr = 1'b0;
        sum         = {1'b0, count} + {1'b0, step_reg};
        step_en     = run & cnt_tick & (step_reg != '0) & ~ctrl_clr & ~ctrl_load;

        if (step_en) begin
            // count above LIMIT means LIMIT was lowered under a live counter
            ovf_evt = (count > limit_reg);
            if (down) begin
                term_evt = ovf_evt | (count < step_reg);
            end else begin
                term_evt = ovf_evt | (sum > {1'b0, limit_reg});
            end

            if (term_evt) begin
                if (wrap) begin
                    count_nxt = down ? limit_reg : '0;
                end else begin
                    count_nxt   = down ? '0 : limit_reg;
                    run_autoclr = 1'b1;
                end
            end else begin
                count_nxt = down ? (count - step_reg) : sum[DATA_W-1:0];
            end
        end

        if (ctrl_load) begin
            count_nxt = load_reg;
        end
        if (ctrl_clr) begin
            count_nxt = '0;
        end
    end

    logic [DATA_W-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (cfg_addr)
            A_CTRL: begin
                rd_mux[0] = run;
                rd_mux[1] = down;
                rd_mux[2] = wrap;
                rd_mux[5] = irq_term_en;
                rd_mux[6] = irq_ovf_en;
            end
            A_LOAD:   rd_mux = load_reg;
            A_LIMIT:  rd_mux = limit_reg;
            A_STEP:   rd_mux = step_reg;
            A_COUNT:  rd_mux = count;
            A_STATUS: begin
                rd_mux[0] = term_sticky;
                rd_mux[1] = ovf_sticky;
            end
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            down        <= 1'b0;
            wrap        <= 1'b0;
            irq_term_en <= 1'b0;
            irq_ovf_en  <= 1'b0;
            load_reg    <= '0;
            limit_reg   <= DATA_W'(RST_LIMIT);
            step_reg    <= DATA_W'(1);
            term_sticky <= 1'b0;
            ovf_sticky  <= 1'b0;
            count       <= '0;
            term_pulse  <= 1'b0;
            cfg_rdata   <= '0;
            cfg_rvalid  <= 1'b0;
        end else begin
            // a CTRL write takes precedence over the run auto-clear
            if (wr_ctrl) begin
                run         <= cfg_wdata[0];
                down        <= cfg_wdata[1];
                wrap        <= cfg_wdata[2];
                irq_term_en <= cfg_wdata[5];
                irq_ovf_en  <= cfg_wdata[6];
            end else if (run_autoclr) begin
                run <= 1'b0;
            end

            if (wr && (cfg_addr == A_LOAD)) begin
                load_reg <= cfg_wdata;
            end
            if (wr && (cfg_addr == A_LIMIT)) begin
                limit_reg <= cfg_wdata;
            end
            if (wr && (cfg_addr == A_STEP)) begin
                step_reg <= cfg_wdata;
            end

            // set beats a same-cycle write-1-to-clear
            term_sticky <= (term_sticky & ~(wr_status & cfg_wdata[0])) | term_evt;
            ovf_sticky  <= (ovf_sticky  & ~(wr_status & cfg_wdata[1])) | ovf_evt;

            count      <= count_nxt;
            term_pulse <= term_evt;

            cfg_rvalid <= rd;
            if (rd) begin
                cfg_rdata <= rd_mux;
            end
        end
    end

    assign irq = (term_sticky & irq_term_en) | (ovf_sticky & irq_ovf_en);

endmodule

// File: tb/tb_pcounter_cfg_resp.sv
// tb/tb_pcounter_cfg_resp.sv - directed self-checking bench for pcounter_cfg_resp
module tb_pcounter_cfg_resp;

    logic       clk;
    logic       rst_n;
    logic       cfg_enable;
    logic       cfg_rd_wr;
    logic [2:0] cfg_addr;
    logic [9:0] cfg_wdata;
    logic [9:0] cfg_rdata;
    logic       cfg_rvalid;
    logic       cnt_tick;
    logic [9:0] count;
    logic       term_pulse;
    logic       irq;

    int n_chk;
    int n_bad;

    pcounter_cfg_resp #(.DATA_W(10), .ADDR_W(3), .RST_LIMIT(1023)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_enable (cfg_enable),
        .cfg_rd_wr  (cfg_rd_wr),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .cfg_rvalid (cfg_rvalid),
        .cnt_tick   (cnt_tick),
        .count      (count),
        .term_pulse (term_pulse),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [9:0] d);
        @(negedge clk);
        cfg_enable = 1'b1;
        cfg_rd_wr  = 1'b1;
        cfg_addr   = a;
        cfg_wdata  = d;
        @(negedge clk);
        cfg_enable = 1'b0;
        cfg_rd_wr  = 1'b0;
    endtask

    task automatic bus_rd(input string tag, input logic [2:0] a, input logic [9:0] exp);
        @(negedge clk);
        cfg_enable = 1'b1;
        cfg_rd_wr  = 1'b0;
        cfg_addr   = a;
        @(negedge clk);
        cfg_enable = 1'b0;
        check({tag, "_rvalid"}, cfg_rvalid, 1);
        check(tag, cfg_rdata, exp);
    endtask

    task automatic tick_cycle(input string tag, input logic [9:0] exp_cnt, input logic exp_term);
        cnt_tick = 1'b1;
        @(negedge clk);
        cnt_tick = 1'b0;
        check({tag, "_count"}, count, exp_cnt);
        check({tag, "_term"}, term_pulse, exp_term);
    endtask

    logic [9:0] rst_exp [8];

    initial begin
        n_chk      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        cfg_enable = 1'b0;
        cfg_rd_wr  = 1'b0;
        cfg_addr   = '0;
        cfg_wdata  = '0;
        cnt_tick   = 1'b0;
        rst_exp    = '{10'd0, 10'd0, 10'd1023, 10'd1, 10'd0, 10'd0, 10'd0, 10'd0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_count", count, 0);
        check("rst_rvalid", cfg_rvalid, 0);
        check("rst_rdata", cfg_rdata, 0);
        check("rst_term", term_pulse, 0);
        check("rst_irq", irq, 0);

        // back-to-back reads of the whole map, one cycle latency each
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("map_rvalid%0d", i - 1), cfg_rvalid, 1);
                check($sformatf("map_rdata%0d", i - 1), cfg_rdata, rst_exp[i-1]);
            end
            if (i < 8) begin
                cfg_enable = 1'b1;
                cfg_rd_wr  = 1'b0;
                cfg_addr   = 3'(i);
            end else begin
                cfg_enable = 1'b0;
            end
        end
        @(negedge clk);
        check("map_idle_rvalid", cfg_rvalid, 0);
        check("map_idle_rdata_hold", cfg_rdata, 0);

        // up count with wrap: 0,2,4,0
        bus_wr(3'd2, 10'd5);
        bus_wr(3'd3, 10'd2);
        bus_wr(3'd0, 10'h005);
        check("up_start", count, 0);
        tick_cycle("up1", 10'd2, 1'b0);
        tick_cycle("up2", 10'd4, 1'b0);
        tick_cycle("up3", 10'd0, 1'b1);
        @(negedge clk);
        check("up_term_clear", term_pulse, 0);
        bus_rd("up_status", 3'd5, 10'd1);
        check("up_irq_off", irq, 0);

        // down count from LOAD without wrap: 3,1,0 then run drops
        bus_wr(3'd5, 10'd3);
        bus_wr(3'd1, 10'd3);
        bus_wr(3'd0, 10'h013);
        check("dn_load", count, 3);
        bus_rd("dn_ctrl_rd", 3'd0, 10'd3);
        tick_cycle("dn1", 10'd1, 1'b0);
        tick_cycle("dn2", 10'd0, 1'b1);
        bus_rd("dn_run_clr", 3'd0, 10'd2);
        tick_cycle("dn_hold1", 10'd0, 1'b0);
        tick_cycle("dn_hold2", 10'd0, 1'b0);
        bus_rd("dn_status", 3'd5, 10'd1);

        // LIMIT lowered under a running counter -> overflow
        bus_wr(3'd5, 10'd3);
        bus_wr(3'd2, 10'd20);
        bus_wr(3'd1, 10'd8);
        bus_wr(3'd0, 10'h015);
        check("ovf_w_load", count, 8);
        bus_wr(3'd2, 10'd4);
        tick_cycle("ovf_w", 10'd0, 1'b1);
        bus_rd("ovf_w_status", 3'd5, 10'd3);
        bus_wr(3'd2, 10'd20);
        bus_wr(3'd0, 10'h011);
        check("ovf_n_load", count, 8);
        bus_wr(3'd2, 10'd4);
        tick_cycle("ovf_n", 10'd4, 1'b1);
        bus_rd("ovf_n_ctrl", 3'd0, 10'd0);
        bus_rd("ovf_n_status", 3'd5, 10'd3);

        // irq from enabled sticky bits, W1C one at a time
        bus_wr(3'd0, 10'h060);
        check("irq_on", irq, 1);
        bus_rd("irq_ctrl", 3'd0, 10'h060);
        bus_wr(3'd5, 10'd1);
        bus_rd("irq_status2", 3'd5, 10'd2);
        check("irq_still", irq, 1);
        bus_wr(3'd5, 10'd2);
        check("irq_off", irq, 0);
        bus_rd("irq_status0", 3'd5, 10'd0);

        // read-only COUNT and reserved addresses
        bus_wr(3'd4, 10'd7);
        bus_rd("count_ro", 3'd4, 10'd4);
        bus_wr(3'd6, 10'd5);
        bus_rd("rsvd_rd", 3'd6, 10'd0);

        // COUNT read in a step cycle returns the pre-step value
        bus_wr(3'd2, 10'd20);
        bus_wr(3'd3, 10'd1);
        bus_wr(3'd0, 10'h001);
        @(negedge clk);
        cnt_tick   = 1'b1;
        cfg_enable = 1'b1;
        cfg_rd_wr  = 1'b0;
        cfg_addr   = 3'd4;
        @(negedge clk);
        cnt_tick   = 1'b0;
        cfg_enable = 1'b0;
        check("pre_rvalid", cfg_rvalid, 1);
        check("pre_rdata", cfg_rdata, 4);
        check("pre_count", count, 5);

        // reset while running with a read response in flight
        cnt_tick   = 1'b1;
        cfg_enable = 1'b1;
        cfg_addr   = 3'd2;
        @(posedge clk);
        #1;
        check("mid_rvalid_pre", cfg_rvalid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_count", count, 0);
        check("mid_rvalid", cfg_rvalid, 0);
        check("mid_rdata", cfg_rdata, 0);
        check("mid_term", term_pulse, 0);
        check("mid_irq", irq, 0);
        cfg_enable = 1'b0;
        cnt_tick   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rvalid", cfg_rvalid, 0);
        check("post_count", count, 0);
        bus_rd("post_limit", 3'd2, 10'd1023);
        bus_rd("post_ctrl", 3'd0, 10'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
